// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - prioritised stall/flush generator with divider counter and fetch tracker
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exc_flush,
    input  logic       d_wait,
    input  logic       div_start,
    input  logic       ex_load,
    input  logic [4:0] ex_wreg,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       i_req,
    input  logic       i_addr_ok,
    input  logic       i_data_ok,
    output logic [4:0] stall,
    output logic [4:0] flush,
    output logic       div_ready,
    output logic       i_discard
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
    typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DISCARD} i_state_e;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    div_state_e div_state_q, div_state_d;
    i_state_e   i_state_q, i_state_d;
    logic [5:0] cnt_q, cnt_d;

    logic       load_use;
    logic       div_busy;
    logic       i_stall;
    logic [2:0] depth;

    always_comb begin
        load_use = ex_load && (ex_wreg != 5'd0) &&
                   ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
        div_busy = (div_state_q == DIV_RUN) || ((div_state_q == DIV_IDLE) && div_start);
        i_stall  = ((i_state_q == I_IDLE) && i_req && !i_addr_ok) ||
                   ((i_state_q == I_WAIT) && !i_data_ok) ||
                   (i_state_q == I_DISCARD);
        div_ready = (div_state_q == DIV_DONE);
        i_discard = (i_state_q == I_DISCARD);
    end

    // Stall depth d freezes registers 0..d-1 and bubbles register d.
    always_comb begin
        depth = 3'd0;
        if (d_wait)        depth = 3'd4;
        else if (div_busy) depth = 3'd3;
        else if (load_use) depth = 3'd2;
        else if (i_stall)  depth = 3'd1;

        stall = 5'b00000;
        flush = 5'b00000;
        if (exc_flush) begin
            flush = 5'b11110;
        end else begin
            case (depth)
                3'd1:    begin stall = 5'b00001; flush = 5'b00010; end
                3'd2:    begin stall = 5'b00011; flush = 5'b00100; end
                3'd3:    begin stall = 5'b00111; flush = 5'b01000; end
                3'd4:    begin stall = 5'b01111; flush = 5'b10000; end
                default: begin stall = 5'b00000; flush = 5'b00000; end
            endcase
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        cnt_d       = cnt_q;
        case (div_state_q)
            DIV_IDLE: if (div_start) begin
                div_state_d = DIV_RUN;
                cnt_d       = DIV_LOAD;
            end
            DIV_RUN: begin
                if (cnt_q == 6'd1) div_state_d = DIV_DONE;
                else               cnt_d = cnt_q - 6'd1;
            end
            // Result is held until the divide actually leaves EX.
            DIV_DONE: if (!stall[2]) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
        endcase
        if (exc_flush) begin
            div_state_d = DIV_IDLE;
            cnt_d       = 6'd0;
        end
    end

    always_comb begin
        i_state_d = i_state_q;
        case (i_state_q)
            I_IDLE: if (i_req && i_addr_ok) i_state_d = I_WAIT;
            I_WAIT: begin
                if (i_data_ok)      i_state_d = I_IDLE;
                else if (exc_flush) i_state_d = I_DISCARD;
            end
            I_DISCARD: if (i_data_ok) i_state_d = I_IDLE;
            default:   i_state_d = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state_q <= DIV_IDLE;
            i_state_q   <= I_IDLE;
            cnt_q       <= 6'd0;
        end else begin
            div_state_q <= div_state_d;
            i_state_q   <= i_state_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed-vector bench for pipe_hazard_ctrl with DIV_CYCLES=4
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       exc_flush, d_wait, div_start, ex_load;
    logic [4:0] ex_wreg, id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic       i_req, i_addr_ok, i_data_ok;
    logic [4:0] stall, flush;
    logic       div_ready, i_discard;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_flush(exc_flush), .d_wait(d_wait), .div_start(div_start),
        .ex_load(ex_load), .ex_wreg(ex_wreg), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .i_req(i_req), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .stall(stall), .flush(flush), .div_ready(div_ready), .i_discard(i_discard)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] e_stall, input logic [4:0] e_flush,
                             input logic e_ready, input logic e_discard);
        check_eq({tag, ".stall"}, 32'(stall), 32'(e_stall));
        check_eq({tag, ".flush"}, 32'(flush), 32'(e_flush));
        check_eq({tag, ".div_ready"}, 32'(div_ready), 32'(e_ready));
        check_eq({tag, ".i_discard"}, 32'(i_discard), 32'(e_discard));
    endtask

    // Advance to the next cycle; inputs are driven 2ns after the edge.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        exc_flush = 0; d_wait = 0; div_start = 0; ex_load = 0;
        ex_wreg = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        i_req = 0; i_addr_ok = 0; i_data_ok = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #12;
        check_out("reset_held", 5'b00000, 5'b00000, 0, 0);
        check_eq("reset_cnt", 32'(dut.cnt_q), 32'd0);
        nxt();
        rst_n = 1;
        #1 check_out("after_reset", 5'b00000, 5'b00000, 0, 0);

        // Load-use hazard (combinational only)
        ex_load = 1; ex_wreg = 5; id_rs = 5; id_use_rs = 1;
        #1 check_out("load_use_rs", 5'b00011, 5'b00100, 0, 0);
        ex_wreg = 0; id_rs = 0;
        #1 check_out("load_use_r0", 5'b00000, 5'b00000, 0, 0);
        ex_wreg = 7; id_rs = 3; id_rt = 7; id_use_rt = 1;
        #1 check_out("load_use_rt", 5'b00011, 5'b00100, 0, 0);
        id_use_rt = 0;
        #1 check_out("load_use_rt_unused", 5'b00000, 5'b00000, 0, 0);
        ex_load = 0; id_use_rt = 1;
        #1 check_out("no_load", 5'b00000, 5'b00000, 0, 0);
        clear_inputs();

        // Exception beats data wait
        exc_flush = 1; d_wait = 1;
        #1 check_out("exc_vs_dwait", 5'b00000, 5'b11110, 0, 0);
        exc_flush = 0;
        #1 check_out("dwait_only", 5'b01111, 5'b10000, 0, 0);
        clear_inputs();

        // Plain divide: busy cycles 1..4, ready in cycle 5
        nxt();
        div_start = 1;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) nxt();
            #1 check_out($sformatf("div_busy_c%0d", c), 5'b00111, 5'b01000, 0, 0);
        end
        nxt();
        #1 check_out("div_ready_c5", 5'b00000, 5'b00000, 1, 0);
        nxt();
        div_start = 0;
        #1 check_out("div_idle_c6", 5'b00000, 5'b00000, 0, 0);

        // Divide overlapped by d_wait in cycles 3..6
        nxt();
        div_start = 1;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) nxt();
            d_wait = (c >= 3 && c <= 6);
            if (c == 8) div_start = 0;
            #1;
            if (c <= 2)      check_out($sformatf("divw_c%0d", c), 5'b00111, 5'b01000, 0, 0);
            else if (c <= 4) check_out($sformatf("divw_c%0d", c), 5'b01111, 5'b10000, 0, 0);
            else if (c <= 6) check_out($sformatf("divw_c%0d", c), 5'b01111, 5'b10000, 1, 0);
            else if (c == 7) check_out("divw_c7", 5'b00000, 5'b00000, 1, 0);
            else             check_out("divw_c8", 5'b00000, 5'b00000, 0, 0);
        end
        clear_inputs();

        // Exception during DIV_RUN and I_WAIT
        nxt();
        div_start = 1; i_req = 1; i_addr_ok = 1;
        #1 check_out("exc_setup_c1", 5'b00111, 5'b01000, 0, 0);
        nxt();
        i_req = 0; i_addr_ok = 0;
        #1 check_out("exc_setup_c2", 5'b00111, 5'b01000, 0, 0);
        nxt();
        exc_flush = 1;
        #1 check_out("exc_cycle", 5'b00000, 5'b11110, 0, 0);
        nxt();
        exc_flush = 0; div_start = 0;
        #1 check_out("discard_c1", 5'b00001, 5'b00010, 0, 1);
        nxt();
        i_req = 1; i_addr_ok = 1;
        #1 check_out("discard_req_ignored", 5'b00001, 5'b00010, 0, 1);
        nxt();
        i_req = 0; i_addr_ok = 0; i_data_ok = 1;
        #1 check_out("discard_data", 5'b00001, 5'b00010, 0, 1);
        nxt();
        i_data_ok = 0;
        #1 check_out("discard_done", 5'b00000, 5'b00000, 0, 0);

        // Exception coinciding with returning data: no discard
        nxt();
        i_req = 1; i_addr_ok = 1;
        nxt();
        i_req = 0; i_addr_ok = 0; exc_flush = 1; i_data_ok = 1;
        #1 check_out("exc_with_data", 5'b00000, 5'b11110, 0, 0);
        nxt();
        clear_inputs();
        #1 check_out("exc_with_data_after", 5'b00000, 5'b00000, 0, 0);

        // Fetch back-pressure then data wait
        for (int c = 1; c <= 8; c++) begin
            nxt();
            i_req     = (c <= 4);
            i_addr_ok = (c == 4);
            i_data_ok = (c == 7);
            #1;
            if (c <= 3 || c == 5 || c == 6)
                check_out($sformatf("fetch_c%0d", c), 5'b00001, 5'b00010, 0, 0);
            else
                check_out($sformatf("fetch_c%0d", c), 5'b00000, 5'b00000, 0, 0);
        end
        clear_inputs();

        // Async reset mid-DIV_RUN
        nxt();
        div_start = 1;
        nxt();
        div_start = 0;
        #1 check_out("pre_reset_run", 5'b00111, 5'b01000, 0, 0);
        rst_n = 0;
        #1 check_out("async_reset", 5'b00000, 5'b00000, 0, 0);
        check_eq("async_reset_cnt", 32'(dut.cnt_q), 32'd0);
        nxt();
        rst_n = 1;
        nxt();
        #1 check_out("post_reset_idle", 5'b00000, 5'b00000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
